wb_cmd_master: RTL and testbench

Wishbone classic-cycle initiator that turns single read/write commands from a valid/ready command port into Wishbone bus cycles toward a master socket. It handles slave termination (ack/err/rty), bounded retry and a bus timeout, then returns read data and a status code on a valid/ready response port. It sits between a processor-side or DMA-side command source and the wishbone bus fabric.

---
 rtl/wb_bus_pkg.sv | 18 +
 rtl/wb_timeout_cnt.sv | 42 ++++
 rtl/wb_cmd_master.sv | 172 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_pkg.sv
// Shared Wishbone initiator definitions: response status codes and FSM state encoding.
package wb_bus_pkg;

   // Response status codes returned on rsp_status_o.
   localparam logic [1:0] STAT_OK       = 2'b00;
   localparam logic [1:0] STAT_ERR      = 2'b01;
   localparam logic [1:0] STAT_TIMEOUT  = 2'b10;
   localparam logic [1:0] STAT_RETRY_EX = 2'b11;

   // Command master FSM states.
   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_BUS     = 2'b01,
      S_BACKOFF = 2'b10,
      S_RESP    = 2'b11
   } state_e;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th enabled cycle is being spent.
// TIMEOUT = 0 disables the watchdog (never expires, never counts).
module wb_timeout_cnt #(
   parameter int TIMEOUT = 255
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int             CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam bit             ENABLED = (TIMEOUT > 0);
   localparam logic [CW-1:0]  LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] cnt_q, cnt_d;

   // Expiry is decoded from the counter alone so it never depends on en_i.
   assign expired_o = ENABLED && (cnt_q == LAST);

   // Next count: clear wins, otherwise count enabled cycles and stop at the limit.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (ENABLED && en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator. One command in, one bus transaction
// (with bounded retry and a watchdog), one response out.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid holds its payload stable until that edge.
module wb_cmd_master
   import wb_bus_pkg::*;
#(
   parameter int Dw        = 32,
   parameter int Aw        = 32,
   parameter int SELw      = 4,
   parameter int TAGw      = 3,
   parameter int MAX_RETRY = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic            cmd_we_i,
   input  logic [Aw-1:0]   cmd_adr_i,
   input  logic [Dw-1:0]   cmd_dat_i,
   input  logic [SELw-1:0] cmd_sel_i,
   input  logic [TAGw-1:0] cmd_tag_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [Dw-1:0]   rsp_dat_o,
   output logic [1:0]      rsp_status_o,
   output logic [Aw-1:0]   adr_o,
   output logic [Dw-1:0]   dat_o,
   output logic [SELw-1:0] sel_o,
   output logic [TAGw-1:0] tag_o,
   output logic            we_o,
   output logic            cyc_o,
   output logic            stb_o,
   input  logic [Dw-1:0]   dat_i,
   input  logic            ack_i,
   input  logic            err_i,
   input  logic            rty_i,
   output state_e          state_o
);

   localparam int            RW          = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   state_e          state_q, state_d;
   logic [Aw-1:0]   adr_q, adr_d;
   logic [Dw-1:0]   dat_q, dat_d;
   logic [SELw-1:0] sel_q, sel_d;
   logic [TAGw-1:0] tag_q, tag_d;
   logic            we_q, we_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [Dw-1:0]   rsp_dat_q, rsp_dat_d;
   logic [1:0]      rsp_status_q, rsp_status_d;
   logic            tmo_clr, tmo_en, tmo_expired;

   wb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_tmo (
      .clk_i     (clk),
      .rst_ni    (reset),
      .clr_i     (tmo_clr),
      .en_i      (tmo_en),
      .expired_o (tmo_expired)
   );

   // All handshake and bus-control outputs decode straight from flops.
   assign cmd_ready_o  = (state_q == S_IDLE) && reset;
   assign rsp_valid_o  = (state_q == S_RESP);
   assign cyc_o        = (state_q == S_BUS);
   assign stb_o        = (state_q == S_BUS);
   assign adr_o        = adr_q;
   assign dat_o        = dat_q;
   assign sel_o        = sel_q;
   assign tag_o        = tag_q;
   assign we_o         = we_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_status_o = rsp_status_q;
   assign state_o      = state_q;

   // Next-state and datapath decode; terminations only matter in S_BUS, err > ack > rty.
   always_comb begin
      state_d      = state_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      sel_d        = sel_q;
      tag_d        = tag_q;
      we_d         = we_q;
      retry_d      = retry_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      tmo_clr      = 1'b1;
      tmo_en       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               adr_d   = cmd_adr_i;
               dat_d   = cmd_dat_i;
               sel_d   = cmd_sel_i;
               tag_d   = cmd_tag_i;
               we_d    = cmd_we_i;
               retry_d = '0;
               state_d = S_BUS;
            end
         end
         S_BUS: begin
            tmo_clr = 1'b0;
            if (err_i) begin
               rsp_status_d = STAT_ERR;
               rsp_dat_d    = '0;
               state_d      = S_RESP;
            end else if (ack_i) begin
               rsp_status_d = STAT_OK;
               rsp_dat_d    = we_q ? '0 : dat_i;
               state_d      = S_RESP;
            end else if (rty_i) begin
               if (retry_q < RETRY_LIMIT) begin
                  retry_d = retry_q + 1'b1;
                  state_d = S_BACKOFF;
               end else begin
                  rsp_status_d = STAT_RETRY_EX;
                  rsp_dat_d    = '0;
                  state_d      = S_RESP;
               end
            end else begin
               tmo_en = 1'b1;
               if (tmo_expired) begin
                  rsp_status_d = STAT_TIMEOUT;
                  rsp_dat_d    = '0;
                  state_d      = S_RESP;
               end
            end
         end
         S_BACKOFF: begin
            state_d = S_BUS;
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, request and response registers; reset drops the bus at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         adr_q        <= '0;
         dat_q        <= '0;
         sel_q        <= '0;
         tag_q        <= '0;
         we_q         <= 1'b0;
         retry_q      <= '0;
         rsp_dat_q    <= '0;
         rsp_status_q <= STAT_OK;
      end else begin
         state_q      <= state_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         sel_q        <= sel_d;
         tag_q        <= tag_d;
         we_q         <= we_d;
         retry_q      <= retry_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
      end
   end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: scripted Wishbone slave, command driver,
// response scoreboard keyed on {status, data}.
module tb_wb_cmd_master;
   import wb_bus_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_we_i    = 1'b0;
   logic [31:0] cmd_adr_i   = '0;
   logic [31:0] cmd_dat_i   = '0;
   logic [3:0]  cmd_sel_i   = '0;
   logic [2:0]  cmd_tag_i   = '0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic [31:0] adr_o, dat_o;
   logic [3:0]  sel_o;
   logic [2:0]  tag_o;
   logic        we_o, cyc_o, stb_o;
   logic [31:0] dat_i = '0;
   logic        ack_i = 1'b0;
   logic        err_i = 1'b0;
   logic        rty_i = 1'b0;
   state_e      state_o;

   wb_cmd_master #(
      .Dw(32), .Aw(32), .SELw(4), .TAGw(3), .MAX_RETRY(3), .TIMEOUT(255)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .cmd_valid_i  (cmd_valid_i),
      .cmd_ready_o  (cmd_ready_o),
      .cmd_we_i     (cmd_we_i),
      .cmd_adr_i    (cmd_adr_i),
      .cmd_dat_i    (cmd_dat_i),
      .cmd_sel_i    (cmd_sel_i),
      .cmd_tag_i    (cmd_tag_i),
      .rsp_valid_o  (rsp_valid_o),
      .rsp_ready_i  (rsp_ready_i),
      .rsp_dat_o    (rsp_dat_o),
      .rsp_status_o (rsp_status_o),
      .adr_o        (adr_o),
      .dat_o        (dat_o),
      .sel_o        (sel_o),
      .tag_o        (tag_o),
      .we_o         (we_o),
      .cyc_o        (cyc_o),
      .stb_o        (stb_o),
      .dat_i        (dat_i),
      .ack_i        (ack_i),
      .err_i        (err_i),
      .rty_i        (rty_i),
      .state_o      (state_o)
   );

   // ---------------- scoreboard state ----------------
   logic [33:0] exp_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scripted slave ----------------
   // Each entry answers one strobe attempt: waits, then term = {err,ack,rty}.
   typedef struct {
      int          waits;
      logic [2:0]  term;
      logic [31:0] dat;
   } slv_t;
   slv_t slv_q[$];
   slv_t cur;
   bit   busy = 1'b0;
   int   wcnt = 0;

   // Slave drives on the falling edge so inputs are settled at the rising edge.
   always @(negedge clk) begin
      ack_i = 1'b0;
      err_i = 1'b0;
      rty_i = 1'b0;
      dat_i = $urandom;
      if (!reset) begin
         busy = 1'b0;
      end else if (stb_o) begin
         if (!busy && slv_q.size() > 0) begin
            cur  = slv_q.pop_front();
            busy = 1'b1;
            wcnt = cur.waits;
         end
         if (busy) begin
            if (wcnt > 0) begin
               wcnt--;
            end else begin
               {err_i, ack_i, rty_i} = cur.term;
               dat_i = cur.dat;
               busy  = 1'b0;
            end
         end
      end
   end

   task automatic push_attempt(input int waits, input logic [2:0] term, input logic [31:0] dat);
      slv_t s;
      s.waits = waits;
      s.term  = term;
      s.dat   = dat;
      slv_q.push_back(s);
   endtask

   // ---------------- driver ----------------
   task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [2:0] tag,
                          input logic [33:0] exp_word, input int exp_lat,
                          input int exp_stb, input int hold);
      int n;
      int lat;
      int stb;
      logic [33:0] e;
      exp_q.push_back(exp_word);
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_we_i    = we;
      cmd_adr_i   = adr;
      cmd_dat_i   = dat;
      cmd_sel_i   = sel;
      cmd_tag_i   = tag;
      n = 0;
      while (!cmd_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accept_bound", 64'(n < 50), 64'(1));
      @(negedge clk);
      cmd_valid_i = 1'b0;
      check("bus_req", {cyc_o, stb_o, we_o, adr_o, sel_o, tag_o}, {1'b1, 1'b1, we, adr, sel, tag});
      if (we) check("bus_wdat", 64'(dat_o), 64'(dat));
      lat = 1;
      stb = 0;
      while (!rsp_valid_o && lat < 2000) begin
         if (stb_o) stb++;
         @(negedge clk);
         lat++;
      end
      check("rsp_latency", 64'(lat), 64'(exp_lat));
      check("stb_cycles", 64'(stb), 64'(exp_stb));
      check("bus_idle_in_resp", {cyc_o, stb_o}, 2'b00);
      for (int i = 0; i < hold; i++) begin
         check("rsp_hold", {rsp_valid_o, cmd_ready_o, rsp_status_o, rsp_dat_o}, {1'b1, 1'b0, exp_q[0]});
         @(negedge clk);
      end
      rsp_ready_i = 1'b1;
      e = exp_q.pop_front();
      check("rsp_word", {rsp_status_o, rsp_dat_o}, e);
      @(negedge clk);
      rsp_ready_i = 1'b0;
      check("ready_after_rsp", {cmd_ready_o, rsp_valid_o}, 2'b10);
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_bus"}, {cyc_o, stb_o, we_o}, 3'b000);
      check({pfx, "_req"}, {adr_o, dat_o, sel_o, tag_o}, '0);
      check({pfx, "_hs"}, {cmd_ready_o, rsp_valid_o}, 2'b00);
      check({pfx, "_rsp"}, {rsp_status_o, rsp_dat_o}, '0);
      check({pfx, "_state"}, 64'(state_o), 64'(S_IDLE));
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int n;
      int nret, w, lat, stb, kind;
      logic we;
      logic [31:0] d;
      logic [33:0] ew;

      repeat (3) @(negedge clk);
      #1 check_reset_vals("reset");
      @(negedge clk);
      reset = 1'b1;
      #1 check("ready_after_release", 64'(cmd_ready_o), 64'(1));

      // Zero-wait write.
      push_attempt(0, 3'b010, 32'h0);
      run_cmd(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 3'd1, {2'b00, 32'h0}, 2, 1, 0);

      // Read with three wait states.
      push_attempt(3, 3'b010, 32'h12345678);
      run_cmd(1'b0, 32'h200, 32'h0, 4'hF, 3'd2, {2'b00, 32'h12345678}, 5, 4, 0);

      // Two retries then ack.
      push_attempt(0, 3'b001, 32'h0);
      push_attempt(0, 3'b001, 32'h0);
      push_attempt(0, 3'b010, 32'hCAFEF00D);
      run_cmd(1'b0, 32'h204, 32'h0, 4'h3, 3'd3, {2'b00, 32'hCAFEF00D}, 6, 3, 0);

      // Retries exhausted on the fourth rty.
      for (int i = 0; i < 4; i++) push_attempt(0, 3'b001, 32'h0);
      run_cmd(1'b0, 32'h208, 32'h0, 4'hF, 3'd4, {2'b11, 32'h0}, 8, 4, 0);

      // Silent slave: watchdog fires after 255 strobe cycles.
      run_cmd(1'b0, 32'h300, 32'h0, 4'hF, 3'd5, {2'b10, 32'h0}, 256, 255, 0);

      // Simultaneous terminations follow err > ack > rty.
      push_attempt(0, 3'b110, 32'h0);
      run_cmd(1'b0, 32'h304, 32'h0, 4'hF, 3'd6, {2'b01, 32'h0}, 2, 1, 0);
      push_attempt(0, 3'b101, 32'h0);
      run_cmd(1'b1, 32'h308, 32'h11112222, 4'h1, 3'd7, {2'b01, 32'h0}, 2, 1, 0);
      push_attempt(1, 3'b011, 32'hA5A5_0F0F);
      run_cmd(1'b0, 32'h30C, 32'h0, 4'hC, 3'd0, {2'b00, 32'hA5A5_0F0F}, 3, 2, 0);

      // Response held back for ten cycles.
      push_attempt(2, 3'b010, 32'h0);
      run_cmd(1'b1, 32'h400, 32'h0BADF00D, 4'h6, 3'd2, {2'b00, 32'h0}, 4, 3, 10);

      // Random mix of retries, wait states, err/ack.
      for (int k = 0; k < 8; k++) begin
         we   = 1'($urandom_range(0, 1));
         nret = $urandom_range(0, 2);
         lat  = 0;
         stb  = 0;
         for (int r = 0; r < nret; r++) begin
            w = $urandom_range(0, 2);
            push_attempt(w, 3'b001, 32'h0);
            stb += w + 1;
            lat += w + 2;
         end
         w    = $urandom_range(0, 2);
         kind = $urandom_range(0, 3);
         d    = $urandom;
         stb += w + 1;
         lat += w + 2;
         if (kind == 0) begin
            push_attempt(w, 3'b100, 32'h0);
            ew = {2'b01, 32'h0};
         end else begin
            push_attempt(w, 3'b010, d);
            ew = we ? {2'b00, 32'h0} : {2'b00, d};
         end
         run_cmd(we, $urandom, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                 ew, lat, stb, $urandom_range(0, 3));
      end

      // Reset in the middle of a bus cycle.
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b1;
      cmd_adr_i   = 32'h500;
      cmd_dat_i   = 32'h55555555;
      cmd_sel_i   = 4'hF;
      cmd_tag_i   = 3'd7;
      n = 0;
      while (!cmd_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmd_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_bus_active", {cyc_o, stb_o, we_o}, 3'b111);
      #2 reset = 1'b0;
      #1 check_reset_vals("mid_bus_reset");
      @(negedge clk);
      reset = 1'b1;
      #1 check("ready_after_mid_release", 64'(cmd_ready_o), 64'(1));

      // Fresh command after the abort.
      push_attempt(0, 3'b010, 32'h7777_8888);
      run_cmd(1'b0, 32'h600, 32'h0, 4'hF, 3'd1, {2'b00, 32'h7777_8888}, 2, 1, 0);

      check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
